// File: rtl/video_mem_ctrl.sv
// Video memory controller: fixed-priority CPU/fill write port and 2-cycle cell scanout.
// Define VIDEO_MEM_CTRL_FILL_EN to build in the screen-fill engine.
module video_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [2:0]  cpu_din,
  input  logic        fill_start,
  input  logic [2:0]  fill_color,
  output logic        fill_busy,
  output logic        fill_done,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_on,
  output logic        ram_we,
  output logic [10:0] ram_addr_write,
  output logic [2:0]  ram_din,
  output logic [10:0] ram_addr_read,
  input  logic [2:0]  ram_dout,
  output logic [2:0]  rgb
);
  localparam int unsigned AW = 11;
  localparam int unsigned CW = 3;

  logic          we_nxt;
  logic [AW-1:0] addr_nxt;
  logic [CW-1:0] din_nxt;
  logic          done_nxt;
  logic          busy_nxt;
  logic          von_d1;
  logic          von_d2;
  logic          unused_bits;

`ifdef VIDEO_MEM_CTRL_FILL_EN
  localparam int unsigned CELLS = 2048;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;
  logic [CW-1:0] color;
  logic [CW-1:0] color_nxt;
  logic          last;

  assign last        = (cnt == AW'(CELLS - 1));
  assign unused_bits = ^{hcount[3:0], vcount[9], vcount[3:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (fill_start) state_nxt = FILL;
    end else begin
      if (!cpu_we && last) state_nxt = IDLE;
    end
  end

  // CPU wins the write slot; the fill only advances on slots the CPU leaves idle
  always_comb begin
    we_nxt    = 1'b0;
    addr_nxt  = ram_addr_write;
    din_nxt   = ram_din;
    done_nxt  = 1'b0;
    cnt_nxt   = cnt;
    color_nxt = color;
    if (cpu_we) begin
      we_nxt   = 1'b1;
      addr_nxt = cpu_addr;
      din_nxt  = cpu_din;
    end else if (state == FILL) begin
      we_nxt   = 1'b1;
      addr_nxt = cnt;
      din_nxt  = color;
      if (last) done_nxt = 1'b1;
      else      cnt_nxt  = cnt + AW'(1);
    end
    if (state == IDLE && fill_start) begin
      cnt_nxt   = '0;
      color_nxt = fill_color;
    end
    busy_nxt = (state_nxt == FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      color <= '0;
    end else begin
      cnt   <= cnt_nxt;
      color <= color_nxt;
    end
  end
`else
  assign unused_bits = ^{hcount[3:0], vcount[9], vcount[3:0], fill_start, fill_color};

  always_comb begin
    we_nxt   = cpu_we;
    addr_nxt = cpu_addr;
    din_nxt  = cpu_din;
    done_nxt = 1'b0;
    busy_nxt = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we         <= 1'b0;
      ram_addr_write <= '0;
      ram_din        <= '0;
      fill_busy      <= 1'b0;
      fill_done      <= 1'b0;
    end else begin
      ram_we         <= we_nxt;
      ram_addr_write <= addr_nxt;
      ram_din        <= din_nxt;
      fill_busy      <= busy_nxt;
      fill_done      <= done_nxt;
    end
  end

  // 16x16 pixel cells: row = vcount[8:4], column = hcount[9:4]
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_read <= '0;
      von_d1        <= 1'b0;
      von_d2        <= 1'b0;
    end else begin
      ram_addr_read <= {vcount[8:4], hcount[9:4]};
      von_d1        <= video_on;
      von_d2        <= von_d1;
    end
  end

  assign rgb = von_d2 ? ram_dout : CW'(0);

endmodule

// File: tb/tb_video_mem_ctrl.sv
// Scoreboard bench for video_mem_ctrl: expected writes and pixels are queued by the
// stimulus and consumed by a negedge monitor; a behavioural 2048x3 RAM closes the loop.
module tb_video_mem_ctrl;
  logic        clk;
  logic        rst;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [2:0]  cpu_din;
  logic        fill_start;
  logic [2:0]  fill_color;
  logic        fill_busy;
  logic        fill_done;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        video_on;
  logic        ram_we;
  logic [10:0] ram_addr_write;
  logic [2:0]  ram_din;
  logic [10:0] ram_addr_read;
  logic [2:0]  ram_dout;
  logic [2:0]  rgb;

  typedef struct packed {
    logic [10:0] addr;
    logic [2:0]  din;
    logic        done;
    logic        busy;
  } wr_t;

  typedef struct {
    int          due;
    logic [10:0] val;
  } pix_t;

  wr_t  wq[$];
  pix_t aq[$];
  pix_t rq[$];

  int   vectors  = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   deadline = -1;
  int   acc_cyc  = 0;
  int   lat_exp  = 0;
  logic rst_q    = 1'b0;

  logic [2:0] mem [0:2047];

  video_mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_din        (cpu_din),
    .fill_start     (fill_start),
    .fill_color     (fill_color),
    .fill_busy      (fill_busy),
    .fill_done      (fill_done),
    .hcount         (hcount),
    .vcount         (vcount),
    .video_on       (video_on),
    .ram_we         (ram_we),
    .ram_addr_write (ram_addr_write),
    .ram_din        (ram_din),
    .ram_addr_read  (ram_addr_read),
    .ram_dout       (ram_dout),
    .rgb            (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 3'b000;
    ram_dout = 3'b000;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_write] <= ram_din;
    ram_dout <= mem[ram_addr_read];
    cyc      <= cyc + 1;
    rst_q    <= rst;
  end

  // monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    wr_t  e;
    pix_t p;
    if (rst_q) begin
      vectors++;
      if ({ram_we, ram_addr_write, ram_din, ram_addr_read, fill_busy, fill_done, rgb} !== '0) begin
        errors++;
        $display("FAIL reset_state: got we=%b wa=%h din=%b ra=%h busy=%b done=%b rgb=%b, want all 0",
                 ram_we, ram_addr_write, ram_din, ram_addr_read, fill_busy, fill_done, rgb);
      end
    end else if (ram_we === 1'b1) begin
      vectors++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got wa=%h din=%b at cycle %0d, want no write",
                 ram_addr_write, ram_din, cyc);
      end else begin
        e = wq.pop_front();
        if ({ram_addr_write, ram_din, fill_done, fill_busy} !== {e.addr, e.din, e.done, e.busy}) begin
          errors++;
          $display("FAIL write: got wa=%h din=%b done=%b busy=%b, want wa=%h din=%b done=%b busy=%b",
                   ram_addr_write, ram_din, fill_done, fill_busy, e.addr, e.din, e.done, e.busy);
        end
      end
    end else begin
      vectors++;
      if (ram_we !== 1'b0 || fill_done !== 1'b0 || (wq.size() == 0 && fill_busy !== 1'b0)) begin
        errors++;
        $display("FAIL idle_state: got we=%b done=%b busy=%b at cycle %0d, want we=0 done=0 busy=0",
                 ram_we, fill_done, fill_busy, cyc);
      end
    end
    if (!rst_q && fill_done === 1'b1) begin
      vectors++;
      if (cyc - acc_cyc != lat_exp) begin
        errors++;
        $display("FAIL fill_latency: got %0d cycles, want %0d", cyc - acc_cyc, lat_exp);
      end
    end
    if (aq.size() > 0 && aq[0].due == cyc) begin
      p = aq.pop_front();
      vectors++;
      if (ram_addr_read !== p.val) begin
        errors++;
        $display("FAIL read_addr: got %h, want %h", ram_addr_read, p.val);
      end
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      p = rq.pop_front();
      vectors++;
      if (rgb !== p.val[2:0]) begin
        errors++;
        $display("FAIL rgb: got %b, want %b", rgb, p.val[2:0]);
      end
    end
    if (cyc == deadline && (wq.size() > 0 || aq.size() > 0 || rq.size() > 0)) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: got %0d writes and %0d pixels outstanding, want 0",
               wq.size(), aq.size() + rq.size());
      wq.delete();
      aq.delete();
      rq.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [2:0] d, input logic busy);
    cpu_we   = 1'b1;
    cpu_addr = a;
    cpu_din  = d;
    wq.push_back('{a, d, 1'b0, busy});
    tick();
    cpu_we   = 1'b0;
  endtask

  task automatic pixel(input logic [9:0] h, input logic [9:0] v, input logic on,
                       input logic [10:0] ea, input logic [2:0] er);
    hcount   = h;
    vcount   = v;
    video_on = on;
    aq.push_back('{cyc + 1, ea});
    rq.push_back('{cyc + 2, 11'(er)});
    tick();
  endtask

  task automatic push_fill(input logic [2:0] c, input int first, input int last_idx, input logic completes);
    for (int k = first; k <= last_idx; k++) begin
      logic fin;
      fin = completes && (k == 2047);
      wq.push_back('{11'(k), c, fin, !fin});
    end
  endtask

  task automatic drain(input int budget);
    deadline = cyc + budget;
    for (int i = 0; i < budget + 2; i++) begin
      if (wq.size() == 0 && aq.size() == 0 && rq.size() == 0) break;
      tick();
    end
    video_on = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = 11'h155;
    cpu_din    = 3'b111;
    fill_start = 1'b1;
    fill_color = 3'b111;
    hcount     = 10'd100;
    vcount     = 10'd100;
    video_on   = 1'b1;
    repeat (3) tick();
    rst        = 1'b0;
    cpu_we     = 1'b0;
    fill_start = 1'b0;
    video_on   = 1'b0;
    repeat (2) tick();

    cpu_write(11'h07F, 3'b101, 1'b0);
    cpu_write(11'h0C2, 3'b110, 1'b0);
    cpu_write(11'h000, 3'b011, 1'b0);
    cpu_write(11'h7FF, 3'b111, 1'b0);
    tick();

    pixel(10'd35,   10'd50,  1'b1, 11'h0C2, 3'b110);
    pixel(10'd35,   10'd50,  1'b0, 11'h0C2, 3'b000);
    pixel(10'd0,    10'd0,   1'b1, 11'h000, 3'b011);
    pixel(10'd15,   10'd15,  1'b1, 11'h000, 3'b011);
    pixel(10'd1023, 10'd511, 1'b1, 11'h7FF, 3'b111);
    pixel(10'd35,   10'd562, 1'b1, 11'h0C2, 3'b110);
    pixel(10'd1010, 10'd20,  1'b1, 11'h07F, 3'b101);
    drain(10);

`ifdef VIDEO_MEM_CTRL_FILL_EN
    // uncontended fill
    lat_exp    = 2048;
    fill_color = 3'b010;
    fill_start = 1'b1;
    push_fill(3'b010, 0, 2047, 1'b1);
    tick();
    acc_cyc    = cyc;
    fill_start = 1'b0;
    drain(2100);

    // CPU steals three slots at counter 100; a second fill_start mid-fill is ignored
    lat_exp    = 2051;
    fill_color = 3'b011;
    fill_start = 1'b1;
    push_fill(3'b011, 0, 99, 1'b0);
    tick();
    acc_cyc    = cyc;
    for (int i = 1; i <= 100; i++) begin
      fill_start = (i == 50);
      fill_color = (i == 50) ? 3'b101 : 3'b011;
      tick();
    end
    fill_start = 1'b0;
    for (int i = 0; i < 3; i++) cpu_write(11'h500, 3'b100, 1'b1);
    push_fill(3'b011, 100, 2047, 1'b1);
    drain(2100);

    // reset at counter 1000 aborts silently; next fill restarts at address 0
    lat_exp    = 0;
    fill_color = 3'b110;
    fill_start = 1'b1;
    push_fill(3'b110, 0, 999, 1'b0);
    tick();
    acc_cyc    = cyc;
    fill_start = 1'b0;
    repeat (1000) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    lat_exp    = 2048;
    fill_color = 3'b001;
    fill_start = 1'b1;
    push_fill(3'b001, 0, 2047, 1'b1);
    tick();
    acc_cyc    = cyc;
    fill_start = 1'b0;
    drain(2100);

    pixel(10'd35,   10'd50,  1'b1, 11'h0C2, 3'b001);
    pixel(10'd1023, 10'd511, 1'b1, 11'h7FF, 3'b001);
    drain(10);
`else
    // fill engine absent: fill_start must produce nothing, CPU path still live
    fill_color = 3'b010;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    repeat (10) tick();
    cpu_write(11'h123, 3'b010, 1'b0);
    repeat (5) tick();
    drain(10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
